aes_key_sched_ctrl: RTL and testbench

- Sequences the 128-bit AES key-expansion core: issues the load pulse, steps it through 10 rounds and drives the Rcon round index.
- Captures all 11 round keys into an internal store.
- Serves round keys to the cipher datapath through a registered read port.
- Sits between the host key-load interface and the encrypt/decrypt round engine.

---
 rtl/aes_key_sched_ctrl.sv | 123 ++++++++++++
 tb/tb_aes_key_sched_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_key_sched_ctrl.sv
// AES-128 key-schedule sequencer: drives the expansion core through NR rounds,
// captures every round key into a local store and serves them on a registered read port.
module aes_key_sched_ctrl #(
    parameter int NR = 10,
    parameter int KW = 128
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          start,
    input  logic          abort,
    input  logic [KW-1:0] key_in,
    output logic          busy,
    output logic          done,
    output logic          rk_valid,
    output logic          exp_load,
    output logic          exp_en,
    output logic [3:0]    exp_round_idx,
    output logic [KW-1:0] exp_key,
    input  logic [KW-1:0] exp_w,
    input  logic          rk_rd_en,
    input  logic [3:0]    rk_rd_addr,
    output logic [KW-1:0] rk_rd_data,
    output logic [2:0]    dbg_state
);

    // Handshake: start is a level sampled on the rising edge only in IDLE or DONE;
    // abort is sampled every edge and overrides start. There is no backpressure.

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_STEP = 3'd2,
        S_FIN  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [3:0] LAST_IDX = 4'(NR - 1);
    localparam logic [3:0] MAX_IDX  = 4'(NR);

    state_t        state, state_nxt;
    logic [3:0]    cnt;
    logic          start_acc;
    logic          rk_we;
    logic [3:0]    rk_wa;
    logic [KW-1:0] rk_wd;
    logic [KW-1:0] rk_mem [0:NR];

    assign dbg_state = state;

    always_comb begin
        state_nxt     = state;
        start_acc     = 1'b0;
        busy          = 1'b0;
        exp_load      = 1'b0;
        exp_en        = 1'b0;
        exp_round_idx = 4'd0;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    start_acc = 1'b1;
                    state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                busy      = 1'b1;
                exp_load  = 1'b1;
                state_nxt = S_STEP;
            end
            S_STEP: begin
                busy          = 1'b1;
                exp_en        = 1'b1;
                exp_round_idx = cnt;
                if (cnt == LAST_IDX) state_nxt = S_FIN;
            end
            S_FIN: begin
                busy      = 1'b1;
                state_nxt = S_DONE;
            end
            default: state_nxt = S_IDLE;
        endcase
        if (abort) begin
            state_nxt = S_IDLE;
            start_acc = 1'b0;
        end
    end

    // The core output lags its step by one cycle, so the key seen during step r
    // (r >= 1) is round key r; the final key arrives in FIN with cnt already at NR.
    always_comb begin
        rk_we = start_acc || (state == S_STEP && cnt != 4'd0) || (state == S_FIN);
        rk_wa = start_acc ? 4'd0 : cnt;
        rk_wd = start_acc ? key_in : exp_w;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= S_IDLE;
            cnt        <= 4'd0;
            exp_key    <= '0;
            rk_valid   <= 1'b0;
            done       <= 1'b0;
            rk_rd_data <= '0;
        end else begin
            state <= state_nxt;
            if (abort || state != S_STEP) cnt <= 4'd0;
            else if (cnt != MAX_IDX)      cnt <= cnt + 4'd1;
            if (start_acc) exp_key <= key_in;
            if (abort || start_acc)     rk_valid <= 1'b0;
            else if (state == S_FIN)    rk_valid <= 1'b1;
            done <= (state == S_FIN) && !abort;
            if (rk_rd_en) begin
                if (rk_valid && rk_rd_addr <= MAX_IDX) rk_rd_data <= rk_mem[rk_rd_addr];
                else                                   rk_rd_data <= '0;
            end
        end
    end

    // Store contents are never exposed unless rk_valid is set, so no reset is needed.
    always_ff @(posedge CLK) begin
        if (rk_we) rk_mem[rk_wa] <= rk_wd;
    end

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Bench for aes_key_sched_ctrl: behavioural AES-128 expansion core plus
// cycle-exact checks of sequencing, abort, reset and the round-key read port.
module tb_aes_key_sched_ctrl;

    localparam int KW = 128;
    localparam logic [127:0] K1     = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] K1_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] K1_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] K2     = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] K2_R10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    logic          CLK;
    logic          RST_N;
    logic          start;
    logic          abort;
    logic [KW-1:0] key_in;
    logic          busy, done, rk_valid, exp_load, exp_en;
    logic [3:0]    exp_round_idx;
    logic [KW-1:0] exp_key;
    logic [KW-1:0] exp_w;
    logic          rk_rd_en;
    logic [3:0]    rk_rd_addr;
    logic [KW-1:0] rk_rd_data;
    logic [2:0]    dbg_state;

    int checks = 0;
    int errors = 0;
    logic [KW-1:0] exp_q[$];
    logic [7:0]    sbox [0:255];
    logic [127:0]  m_rk [0:10];
    logic [127:0]  core_w = '0;
    logic [8:0]    obs_vec;
    logic [KW-1:0] e;

    aes_key_sched_ctrl #(.NR(10), .KW(KW)) dut (
        .CLK(CLK), .RST_N(RST_N), .start(start), .abort(abort), .key_in(key_in),
        .busy(busy), .done(done), .rk_valid(rk_valid), .exp_load(exp_load),
        .exp_en(exp_en), .exp_round_idx(exp_round_idx), .exp_key(exp_key),
        .exp_w(exp_w), .rk_rd_en(rk_rd_en), .rk_rd_addr(rk_rd_addr),
        .rk_rd_data(rk_rd_data), .dbg_state(dbg_state)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    assign obs_vec = {exp_load, exp_en, exp_round_idx, busy, done, rk_valid};
    assign exp_w   = core_w;

    // ---------------- reference model ----------------
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic       hi;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            hi = a[7];
            a  = {a[6:0], 1'b0};
            if (hi) a = a ^ 8'h1b;
            b = {1'b0, b[7:1]};
        end
        return p;
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                          ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] next_rk(input logic [127:0] w, input logic [3:0] r);
        logic [31:0] t, w0, w1, w2, w3;
        logic [7:0]  rc;
        case (r)
            4'd0: rc = 8'h01;  4'd1: rc = 8'h02;  4'd2: rc = 8'h04;  4'd3: rc = 8'h08;
            4'd4: rc = 8'h10;  4'd5: rc = 8'h20;  4'd6: rc = 8'h40;  4'd7: rc = 8'h80;
            4'd8: rc = 8'h1b;  4'd9: rc = 8'h36;  default: rc = 8'h00;
        endcase
        t  = {w[23:0], w[31:24]};
        t  = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
        w0 = w[127:96] ^ t ^ {rc, 24'h0};
        w1 = w[95:64] ^ w0;
        w2 = w[63:32] ^ w1;
        w3 = w[31:0] ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    task automatic build_model(input logic [127:0] k);
        m_rk[0] = k;
        for (int r = 0; r < 10; r++) m_rk[r+1] = next_rk(m_rk[r], 4'(r));
    endtask

    // Expansion core: load or one round step per enabled cycle, one-cycle latency.
    always @(posedge CLK) begin
        if (exp_load)    core_w <= exp_key;
        else if (exp_en) core_w <= next_rk(core_w, exp_round_idx);
    end

    // Expected {exp_load, exp_en, idx, busy, done, rk_valid} in cycle c after start.
    function automatic logic [8:0] exp_vec(input int c);
        logic       ld, en, bz, dn, vl;
        logic [3:0] ix;
        ld = (c == 1);
        en = (c >= 2 && c <= 11);
        ix = en ? 4'(c - 2) : 4'd0;
        bz = (c >= 1 && c <= 12);
        dn = (c == 13);
        vl = (c >= 13);
        return {ld, en, ix, bz, dn, vl};
    endfunction

    function automatic logic [127:0] want_k1(input int a);
        if (a == 0)  return K1;
        if (a == 1)  return K1_R1;
        if (a == 10) return K1_R10;
        return m_rk[a];
    endfunction

    // ---------------- drivers ----------------
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic read_issue(input logic [3:0] a, input logic [KW-1:0] want);
        rk_rd_en   = 1'b1;
        rk_rd_addr = a;
        exp_q.push_back(want);
    endtask

    function automatic logic [127:0] rnd_key();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        RST_N = 1'b0; start = 1'b0; abort = 1'b0; key_in = '0;
        rk_rd_en = 1'b0; rk_rd_addr = 4'd0;
        tick(); tick();
        checks++; if (obs_vec !== 9'b0) begin errors++; $display("FAIL reset_ctrl got=%b want=%b", obs_vec, 9'b0); end
        checks++; if (rk_rd_data !== '0) begin errors++; $display("FAIL reset_rd_data got=%h want=0", rk_rd_data); end
        checks++; if (exp_key !== '0) begin errors++; $display("FAIL reset_exp_key got=%h want=0", exp_key); end
        checks++; if (dbg_state !== 3'd0) begin errors++; $display("FAIL reset_state got=%0d want=0", dbg_state); end
        RST_N = 1'b1;
        tick();
    endtask

    task automatic test_expand();
        build_model(K1);
        checks++; if (obs_vec !== exp_vec(0)) begin errors++; $display("FAIL expand_c0 got=%b want=%b", obs_vec, exp_vec(0)); end
        start = 1'b1; key_in = K1;
        for (int c = 1; c <= 14; c++) begin
            tick();
            start = 1'b0; key_in = rnd_key();
            checks++; if (obs_vec !== exp_vec(c)) begin errors++; $display("FAIL expand_timing c=%0d got=%b want=%b", c, obs_vec, exp_vec(c)); end
            if (c == 13) begin
                checks++; if (exp_key !== K1) begin errors++; $display("FAIL expand_exp_key got=%h want=%h", exp_key, K1); end
            end
        end
        for (int a = 0; a <= 10; a++) begin
            read_issue(4'(a), want_k1(a));
            tick();
            e = exp_q.pop_front();
            checks++; if (rk_rd_data !== e) begin errors++; $display("FAIL expand_rk addr=%0d got=%h want=%h", a, rk_rd_data, e); end
        end
        rk_rd_en = 1'b0;
    endtask

    task automatic test_restart_ignored();
        build_model(K1);
        start = 1'b1; key_in = K1;
        for (int c = 1; c <= 14; c++) begin
            tick();
            checks++; if (obs_vec !== exp_vec(c)) begin errors++; $display("FAIL restart_timing c=%0d got=%b want=%b", c, obs_vec, exp_vec(c)); end
            if (c == 13) begin
                rk_rd_en = 1'b0;
                e = exp_q.pop_front();
                checks++; if (rk_rd_data !== e) begin errors++; $display("FAIL restart_read_in_fin got=%h want=%h", rk_rd_data, e); end
            end
            start  = (c == 2 || c == 7);
            key_in = start ? K2 : rnd_key();
            if (c == 12) read_issue(4'd0, '0);
        end
        for (int a = 0; a <= 10; a++) begin
            read_issue(4'(a), want_k1(a));
            tick();
            e = exp_q.pop_front();
            checks++; if (rk_rd_data !== e) begin errors++; $display("FAIL restart_rk addr=%0d got=%h want=%h", a, rk_rd_data, e); end
        end
        rk_rd_en = 1'b0;
    endtask

    task automatic test_read_bounds();
        read_issue(4'd11, '0);
        tick();
        e = exp_q.pop_front();
        checks++; if (rk_rd_data !== e) begin errors++; $display("FAIL bounds_addr11 got=%h want=%h", rk_rd_data, e); end
        read_issue(4'd15, '0);
        tick();
        e = exp_q.pop_front();
        checks++; if (rk_rd_data !== e) begin errors++; $display("FAIL bounds_addr15 got=%h want=%h", rk_rd_data, e); end
        read_issue(4'd10, K1_R10);
        checks++; if (rk_rd_data !== '0) begin errors++; $display("FAIL bounds_early_data got=%h want=0", rk_rd_data); end
        tick();
        e = exp_q.pop_front();
        checks++; if (rk_rd_data !== e) begin errors++; $display("FAIL bounds_addr10 got=%h want=%h", rk_rd_data, e); end
        rk_rd_en = 1'b0; rk_rd_addr = 4'd3;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (rk_rd_data !== K1_R10) begin errors++; $display("FAIL bounds_hold i=%0d got=%h want=%h", i, rk_rd_data, K1_R10); end
        end
    endtask

    task automatic test_abort();
        start = 1'b1; key_in = K2;
        for (int c = 1; c <= 14; c++) begin
            tick();
            start = 1'b0; key_in = rnd_key();
            if (c <= 6) begin
                checks++; if (obs_vec !== exp_vec(c)) begin errors++; $display("FAIL abort_pre c=%0d got=%b want=%b", c, obs_vec, exp_vec(c)); end
            end else begin
                checks++; if (obs_vec !== 9'b0) begin errors++; $display("FAIL abort_post c=%0d got=%b want=%b", c, obs_vec, 9'b0); end
            end
            abort = (c == 6);
        end
        for (int a = 0; a <= 5; a += 5) begin
            read_issue(4'(a), '0);
            tick();
            e = exp_q.pop_front();
            checks++; if (rk_rd_data !== e) begin errors++; $display("FAIL abort_read addr=%0d got=%h want=%h", a, rk_rd_data, e); end
        end
        rk_rd_en = 1'b0;
        start = 1'b1; abort = 1'b1; key_in = K1;
        for (int i = 0; i < 2; i++) begin
            tick();
            start = 1'b0; abort = 1'b0;
            checks++; if ({dbg_state, obs_vec} !== 12'b0) begin errors++; $display("FAIL abort_wins i=%0d got=%h want=0", i, {dbg_state, obs_vec}); end
        end
        start = 1'b1; key_in = K1;
        for (int c = 1; c <= 14; c++) begin
            tick();
            start = 1'b0; key_in = rnd_key();
            checks++; if (obs_vec !== exp_vec(c)) begin errors++; $display("FAIL abort_fresh c=%0d got=%b want=%b", c, obs_vec, exp_vec(c)); end
        end
        read_issue(4'd10, K1_R10);
        tick();
        e = exp_q.pop_front();
        checks++; if (rk_rd_data !== e) begin errors++; $display("FAIL abort_fresh_rk10 got=%h want=%h", rk_rd_data, e); end
        rk_rd_en = 1'b0;
    endtask

    task automatic test_back_to_back();
        build_model(K2);
        checks++; if (obs_vec !== 9'b000000001) begin errors++; $display("FAIL b2b_c0 got=%b want=%b", obs_vec, 9'b000000001); end
        start = 1'b1; key_in = K2;
        for (int c = 1; c <= 14; c++) begin
            tick();
            start = 1'b0; key_in = rnd_key();
            checks++; if (obs_vec !== exp_vec(c)) begin errors++; $display("FAIL b2b_timing c=%0d got=%b want=%b", c, obs_vec, exp_vec(c)); end
        end
        for (int a = 0; a <= 10; a++) begin
            read_issue(4'(a), (a == 0) ? K2 : (a == 10) ? K2_R10 : m_rk[a]);
            tick();
            e = exp_q.pop_front();
            checks++; if (rk_rd_data !== e) begin errors++; $display("FAIL b2b_rk addr=%0d got=%h want=%h", a, rk_rd_data, e); end
        end
        rk_rd_en = 1'b0;
    endtask

    task automatic test_async_reset();
        start = 1'b1; key_in = K1;
        for (int c = 1; c <= 8; c++) begin
            tick();
            start = 1'b0; key_in = rnd_key();
            if (c < 8) begin
                checks++; if (obs_vec !== exp_vec(c)) begin errors++; $display("FAIL arst_pre c=%0d got=%b want=%b", c, obs_vec, exp_vec(c)); end
            end
        end
        RST_N = 1'b0;
        #1;
        checks++; if ({dbg_state, obs_vec} !== 12'b0) begin errors++; $display("FAIL arst_ctrl got=%h want=0", {dbg_state, obs_vec}); end
        checks++; if ({exp_key, rk_rd_data} !== 256'b0) begin errors++; $display("FAIL arst_data key=%h rd=%h want=0", exp_key, rk_rd_data); end
        tick(); tick(); tick();
        RST_N = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if ({dbg_state, obs_vec} !== 12'b0) begin errors++; $display("FAIL arst_after i=%0d got=%h want=0", i, {dbg_state, obs_vec}); end
        end
        read_issue(4'd0, '0);
        tick();
        e = exp_q.pop_front();
        checks++; if (rk_rd_data !== e) begin errors++; $display("FAIL arst_read got=%h want=%h", rk_rd_data, e); end
        rk_rd_en = 1'b0;
    endtask

    initial begin
        build_sbox();
        test_reset();
        test_expand();
        test_restart_ignored();
        test_read_bounds();
        test_abort();
        test_back_to_back();
        test_async_reset();
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover got=%0d want=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
